// File: rtl/instr_queue.sv
// Circular instruction buffer between fetch and decode with a registered output slot.
// Define INSTR_QUEUE_BYPASS_EN to let a fetch into an empty, unstalled queue skip storage.
module instr_queue #(
  parameter int QueueDepthLog = 4,
  parameter int InstrWidth    = 32,
  parameter int PcWidth       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid_from_fetch,
  input  logic [InstrWidth-1:0]    instr_from_fetch,
  input  logic [PcWidth-1:0]       pc_from_fetch,
  output logic                     is_full_to_fetch,
  input  logic                     is_stall_from_rs,
  input  logic                     is_stall_from_rob,
  input  logic                     is_exception_from_rob,
  output logic                     instr_valid_to_decode,
  output logic [InstrWidth-1:0]    instr_to_decode,
  output logic [PcWidth-1:0]       pc_to_decode,
  output logic [QueueDepthLog:0]   count_out
);

  localparam int Depth = 2 ** QueueDepthLog;

  logic [InstrWidth-1:0]    instr_mem [Depth];
  logic [PcWidth-1:0]       pc_mem    [Depth];
  logic [QueueDepthLog-1:0] head;
  logic [QueueDepthLog-1:0] tail;
  logic [QueueDepthLog:0]   count;

  logic stall;
  logic not_empty;
  logic pop;
  logic push;
  logic bypass;

  assign stall     = is_stall_from_rs | is_stall_from_rob;
  assign not_empty = (count != '0);
  assign pop       = !stall && not_empty;

  // count never exceeds Depth, so its MSB alone marks the full state
  assign is_full_to_fetch = count[QueueDepthLog];

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = instr_valid_from_fetch && !stall && !not_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push      = instr_valid_from_fetch && !is_full_to_fetch && !bypass;
  assign count_out = count;

  always_ff @(posedge clk) begin
    if (push && !is_exception_from_rob) begin
      instr_mem[tail] <= instr_from_fetch;
      pc_mem[tail]    <= pc_from_fetch;
    end
  end

  // Pop decisions use the pre-edge count; a flush discards that cycle's push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      instr_valid_to_decode <= 1'b0;
      instr_to_decode       <= '0;
      pc_to_decode          <= '0;
    end else if (is_exception_from_rob) begin
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      instr_valid_to_decode <= 1'b0;
    end else begin
      if (!stall) begin
        if (not_empty) begin
          instr_to_decode       <= instr_mem[head];
          pc_to_decode          <= pc_mem[head];
          instr_valid_to_decode <= 1'b1;
          head                  <= head + QueueDepthLog'(1);
        end else if (bypass) begin
          instr_to_decode       <= instr_from_fetch;
          pc_to_decode          <= pc_from_fetch;
          instr_valid_to_decode <= 1'b1;
        end else begin
          instr_valid_to_decode <= 1'b0;
        end
      end
      if (push) begin
        tail <= tail + QueueDepthLog'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (QueueDepthLog + 1)'(1);
        2'b01:   count <= count - (QueueDepthLog + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue: reset, latency, fill, stall hold, wrap, flush.
module tb_instr_queue;

  logic        clk;
  logic        rst;
  logic        instr_valid_from_fetch;
  logic [31:0] instr_from_fetch;
  logic [31:0] pc_from_fetch;
  logic        is_full_to_fetch;
  logic        is_stall_from_rs;
  logic        is_stall_from_rob;
  logic        is_exception_from_rob;
  logic        instr_valid_to_decode;
  logic [31:0] instr_to_decode;
  logic [31:0] pc_to_decode;
  logic [4:0]  count_out;

  int checks   = 0;
  int failures = 0;

  instr_queue #(.QueueDepthLog(4), .InstrWidth(32), .PcWidth(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .instr_valid_from_fetch (instr_valid_from_fetch),
    .instr_from_fetch       (instr_from_fetch),
    .pc_from_fetch          (pc_from_fetch),
    .is_full_to_fetch       (is_full_to_fetch),
    .is_stall_from_rs       (is_stall_from_rs),
    .is_stall_from_rob      (is_stall_from_rob),
    .is_exception_from_rob  (is_exception_from_rob),
    .instr_valid_to_decode  (instr_valid_to_decode),
    .instr_to_decode        (instr_to_decode),
    .pc_to_decode           (pc_to_decode),
    .count_out              (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkSlot(input string tag, input logic exp_valid, input logic [31:0] exp_pc,
                           input logic [31:0] exp_instr, input logic [4:0] exp_count);
    checkOutput({tag, ".valid"}, 64'(instr_valid_to_decode), 64'(exp_valid));
    checkOutput({tag, ".count"}, 64'(count_out), 64'(exp_count));
    if (exp_valid) begin
      checkOutput({tag, ".pc"}, 64'(pc_to_decode), 64'(exp_pc));
      checkOutput({tag, ".instr"}, 64'(instr_to_decode), 64'(exp_instr));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic s_rs, input logic s_rob, input logic exc);
    instr_valid_from_fetch = v;
    instr_from_fetch       = ins;
    pc_from_fetch          = pc;
    is_stall_from_rs       = s_rs;
    is_stall_from_rob      = s_rob;
    is_exception_from_rob  = exc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Push n instructions with stall high, then release stall and expect them in order
  task automatic bufferThenDrain(input string tag, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, instrOf(base + 32'(4 * i)), base + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, ".buffered"}, 64'(count_out), 64'(n));
    for (int i = 0; i < n; i++) begin
      tick();
      checkSlot(tag, 1'b1, base + 32'(4 * i), instrOf(base + 32'(4 * i)), 5'(n - 1 - i));
    end
    tick();
    checkSlot({tag, ".empty"}, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkSlot("reset", 1'b0, 32'h0, 32'h0, 5'd0);
    checkOutput("reset.pc", 64'(pc_to_decode), 64'h0);
    checkOutput("reset.instr", 64'(instr_to_decode), 64'h0);
    checkOutput("reset.full", 64'(is_full_to_fetch), 64'h0);
    rst = 1'b0;
    tick();

    // Single push latency
    applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef INSTR_QUEUE_BYPASS_EN
    checkSlot("single.edge1", 1'b1, 32'h100, 32'h0050_0093, 5'd0);
    tick();
    checkSlot("single.edge2", 1'b0, 32'h0, 32'h0, 5'd0);
`else
    checkSlot("single.edge1", 1'b0, 32'h0, 32'h0, 5'd1);
    tick();
    checkSlot("single.edge2", 1'b1, 32'h100, 32'h0050_0093, 5'd0);
    tick();
    checkSlot("single.edge3", 1'b0, 32'h0, 32'h0, 5'd0);
`endif
    checkOutput("single.pc_hold", 64'(pc_to_decode), 64'h100);

    // Fill with stall high: 16 accepted, 17th dropped
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, instrOf(32'(4 * i)), 32'(4 * i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    checkOutput("fill.count", 64'(count_out), 64'd16);
    checkOutput("fill.full", 64'(is_full_to_fetch), 64'h1);
    checkOutput("fill.valid", 64'(instr_valid_to_decode), 64'h0);
    applyStimulus(1'b1, instrOf(32'h40), 32'h40, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("fill.drop_count", 64'(count_out), 64'd16);
    checkOutput("fill.drop_full", 64'(is_full_to_fetch), 64'h1);

    // Drain in order, holding PC 0x20 under a 3-cycle ROB stall
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      checkSlot("drain", 1'b1, 32'(4 * i), instrOf(32'(4 * i)), 5'(15 - i));
      if (i == 8) begin
        is_stall_from_rob = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          checkSlot("stall_hold", 1'b1, 32'h20, instrOf(32'h20), 5'd7);
        end
        is_stall_from_rob = 1'b0;
      end
    end
    tick();
    checkSlot("drain.empty", 1'b0, 32'h0, 32'h0, 5'd0);
    checkOutput("drain.full", 64'(is_full_to_fetch), 64'h0);

    // Wrap-around: tail passes entry 15 on the second batch
    bufferThenDrain("wrap.a", 12, 32'h200);
    bufferThenDrain("wrap.b", 10, 32'h300);

    // Flush with a simultaneous push while 5 entries are buffered
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, instrOf(32'h400 + 32'(4 * i)), 32'h400 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkSlot("preflush", 1'b1, 32'h400, instrOf(32'h400), 5'd5);
    applyStimulus(1'b1, instrOf(32'h500), 32'h500, 1'b0, 1'b0, 1'b1);
    tick();
    checkSlot("flush", 1'b0, 32'h0, 32'h0, 5'd0);
    checkOutput("flush.full", 64'(is_full_to_fetch), 64'h0);
    applyStimulus(1'b1, instrOf(32'h600), 32'h600, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef INSTR_QUEUE_BYPASS_EN
    checkSlot("postflush.edge1", 1'b1, 32'h600, instrOf(32'h600), 5'd0);
`else
    checkSlot("postflush.edge1", 1'b0, 32'h0, 32'h0, 5'd1);
    tick();
    checkSlot("postflush.edge2", 1'b1, 32'h600, instrOf(32'h600), 5'd0);
`endif
    tick();
    checkSlot("postflush.sole", 1'b0, 32'h0, 32'h0, 5'd0);

    // Asynchronous reset mid-stream, observed before the next clock edge
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, instrOf(32'h700 + 32'(4 * i)), 32'h700 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    #2;
    checkSlot("async_rst", 1'b0, 32'h0, 32'h0, 5'd0);
    checkOutput("async_rst.pc", 64'(pc_to_decode), 64'h0);
    checkOutput("async_rst.instr", 64'(instr_to_decode), 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
